// File: rtl/prim_intr_coalesce_pkg.sv
// Shared types and default widths for the interrupt event coalescer.
package prim_intr_coalesce_pkg;

  typedef enum logic {
    CoalIdle  = 1'b0,
    CoalAccum = 1'b1
  } coal_state_e;

  localparam int unsigned DefWidth  = 1;
  localparam int unsigned DefCntW   = 8;
  localparam int unsigned DefTimerW = 16;

endpackage

// File: rtl/prim_intr_coalesce_chan.sv
// One coalescing channel: gathers events into a batch and emits one pulse per batch.
// state     | meaning
// CoalIdle  | nothing pending; events bypass or open a batch
// CoalAccum | batch open; counting events and timing since first event
module prim_intr_coalesce_chan
  import prim_intr_coalesce_pkg::*;
#(
  parameter int unsigned CntW   = DefCntW,
  parameter int unsigned TimerW = DefTimerW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              raw_event_i,
  input  logic              coal_en_i,
  input  logic [CntW-1:0]   thresh_i,
  input  logic [TimerW-1:0] timeout_i,
  input  logic              flush_i,
  output logic              event_intr_o,
  output logic              pending_o,
  output logic              sat_o
);

  coal_state_e       state;
  logic [CntW-1:0]   cnt;
  logic [TimerW-1:0] tmr;
  logic              hit_thresh;
  logic              hit_timeout;
  logic              fire;

  // Compare one bit wider so cnt + event cannot wrap at the all-ones count.
  assign hit_thresh  = ({1'b0, cnt} + {{CntW{1'b0}}, raw_event_i}) >= {1'b0, thresh_i};
  assign hit_timeout = (timeout_i != '0) &&
                       (({1'b0, tmr} + (TimerW+1)'(1)) >= {1'b0, timeout_i});
  // Dropping the enable mid-batch drains it like a flush.
  assign fire        = hit_thresh || hit_timeout || flush_i || !coal_en_i;

  assign pending_o   = (state == CoalAccum);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= CoalIdle;
      cnt          <= '0;
      tmr          <= '0;
      event_intr_o <= 1'b0;
      sat_o        <= 1'b0;
    end else begin
      event_intr_o <= 1'b0;
      case (state)
        CoalIdle: begin
          if (raw_event_i) begin
            if (!coal_en_i || (thresh_i == CntW'(1))) begin
              event_intr_o <= 1'b1;
            end else begin
              state <= CoalAccum;
              cnt   <= CntW'(1);
              tmr   <= '0;
            end
          end
        end
        CoalAccum: begin
          if (fire) begin
            event_intr_o <= 1'b1;
            state        <= CoalIdle;
            cnt          <= '0;
            tmr          <= '0;
            sat_o        <= 1'b0;
          end else begin
            if (!(&tmr)) tmr <= tmr + TimerW'(1);
            if (raw_event_i) begin
              if (&cnt) sat_o <= 1'b1;
              else      cnt   <= cnt + CntW'(1);
            end
          end
        end
        default: state <= CoalIdle;
      endcase
    end
  end

endmodule

// File: rtl/prim_intr_coalesce.sv
// Per-source interrupt event coalescer feeding the interrupt handler's event inputs.
module prim_intr_coalesce
  import prim_intr_coalesce_pkg::*;
#(
  parameter int unsigned Width  = DefWidth,
  parameter int unsigned CntW   = DefCntW,
  parameter int unsigned TimerW = DefTimerW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [Width-1:0]  raw_event_i,
  input  logic [Width-1:0]  cfg_coal_en_i,
  input  logic [CntW-1:0]   cfg_thresh_i,
  input  logic [TimerW-1:0] cfg_timeout_i,
  input  logic              flush_i,
  output logic [Width-1:0]  event_intr_o,
  output logic [Width-1:0]  pending_o,
  output logic [Width-1:0]  sat_o
);

  // A zero threshold behaves as one: every event fires on its own.
  logic [CntW-1:0] thresh_eff;
  assign thresh_eff = (cfg_thresh_i == '0) ? CntW'(1) : cfg_thresh_i;

  for (genvar i = 0; i < Width; i++) begin : g_chan
    prim_intr_coalesce_chan #(
      .CntW   (CntW),
      .TimerW (TimerW)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .raw_event_i  (raw_event_i[i]),
      .coal_en_i    (cfg_coal_en_i[i]),
      .thresh_i     (thresh_eff),
      .timeout_i    (cfg_timeout_i),
      .flush_i      (flush_i),
      .event_intr_o (event_intr_o[i]),
      .pending_o    (pending_o[i]),
      .sat_o        (sat_o[i])
    );
  end

endmodule

// File: tb/tb_prim_intr_coalesce.sv
// Directed bench: wide-counter instance for main scenarios, 2-bit-counter instance for saturation.
module tb_prim_intr_coalesce;

  logic        clk;
  logic        rst_n;

  logic [1:0]  raw_event;
  logic [1:0]  coal_en;
  logic [7:0]  thresh;
  logic [15:0] timeout;
  logic        flush;
  logic [1:0]  event_intr;
  logic [1:0]  pending;
  logic [1:0]  sat;

  logic [1:0]  s_raw;
  logic [1:0]  s_coal;
  logic [1:0]  s_thresh;
  logic [3:0]  s_timeout;
  logic        s_flush;
  logic [1:0]  s_event;
  logic [1:0]  s_pending;
  logic [1:0]  s_sat;

  int n_checks;
  int n_fail;

  prim_intr_coalesce #(.Width(2), .CntW(8), .TimerW(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .raw_event_i   (raw_event),
    .cfg_coal_en_i (coal_en),
    .cfg_thresh_i  (thresh),
    .cfg_timeout_i (timeout),
    .flush_i       (flush),
    .event_intr_o  (event_intr),
    .pending_o     (pending),
    .sat_o         (sat)
  );

  prim_intr_coalesce #(.Width(2), .CntW(2), .TimerW(4)) dut_s (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .raw_event_i   (s_raw),
    .cfg_coal_en_i (s_coal),
    .cfg_thresh_i  (s_thresh),
    .cfg_timeout_i (s_timeout),
    .flush_i       (s_flush),
    .event_intr_o  (s_event),
    .pending_o     (s_pending),
    .sat_o         (s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw_event = '0; coal_en = '0; thresh = '0; timeout = '0; flush = 1'b0;
    s_raw = '0; s_coal = '0; s_thresh = '0; s_timeout = '0; s_flush = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({event_intr, pending, sat} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000", {event_intr, pending, sat});
    end
    n_checks++;
    if ({s_event, s_pending, s_sat} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_small: got %b expected 000000", {s_event, s_pending, s_sat});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    logic exp_ev;
    coal_en = 2'b00; thresh = 8'd4; timeout = '0;
    for (int c = 0; c <= 12; c++) begin
      raw_event = '0;
      raw_event[0] = (c == 3 || c == 4 || c == 9);
      exp_ev = (c == 4 || c == 5 || c == 10);
      n_checks++;
      if (event_intr[0] !== exp_ev) begin
        n_fail++;
        $display("FAIL bypass_pulse c=%0d: got %b expected %b", c, event_intr[0], exp_ev);
      end
      n_checks++;
      if (pending !== 2'b00) begin
        n_fail++;
        $display("FAIL bypass_pending c=%0d: got %b expected 00", c, pending);
      end
      tick();
    end
    raw_event = '0;
  endtask

  task automatic test_threshold();
    logic exp_ev, exp_pend;
    coal_en = 2'b11; thresh = 8'd4; timeout = '0;
    for (int c = 0; c <= 10; c++) begin
      raw_event = '0;
      raw_event[0] = (c == 0 || c == 2 || c == 5 || c == 6);
      exp_ev   = (c == 7);
      exp_pend = (c >= 1 && c <= 6);
      n_checks++;
      if (event_intr !== {1'b0, exp_ev}) begin
        n_fail++;
        $display("FAIL thresh_pulse c=%0d: got %b expected %b", c, event_intr, {1'b0, exp_ev});
      end
      n_checks++;
      if (pending !== {1'b0, exp_pend}) begin
        n_fail++;
        $display("FAIL thresh_pending c=%0d: got %b expected %b", c, pending, {1'b0, exp_pend});
      end
      tick();
    end
    raw_event = '0;
  endtask

  task automatic test_timeout();
    logic exp_ev, exp_pend;
    coal_en = 2'b11; thresh = 8'd10; timeout = 16'd5;
    for (int c = 0; c <= 9; c++) begin
      raw_event = '0;
      raw_event[0] = (c == 0);
      exp_ev   = (c == 6);
      exp_pend = (c >= 1 && c <= 5);
      n_checks++;
      if (event_intr[0] !== exp_ev) begin
        n_fail++;
        $display("FAIL timeout_pulse c=%0d: got %b expected %b", c, event_intr[0], exp_ev);
      end
      n_checks++;
      if (pending[0] !== exp_pend) begin
        n_fail++;
        $display("FAIL timeout_pending c=%0d: got %b expected %b", c, pending[0], exp_pend);
      end
      tick();
    end
    raw_event = '0;
  endtask

  task automatic test_same_cycle_timeout();
    logic exp_ev, exp_pend;
    coal_en = 2'b11; thresh = 8'd10; timeout = 16'd3;
    for (int c = 0; c <= 8; c++) begin
      raw_event = '0;
      raw_event[0] = (c == 0 || c == 3);
      exp_ev   = (c == 4);
      exp_pend = (c >= 1 && c <= 3);
      n_checks++;
      if (event_intr[0] !== exp_ev) begin
        n_fail++;
        $display("FAIL same_cycle_pulse c=%0d: got %b expected %b", c, event_intr[0], exp_ev);
      end
      n_checks++;
      if (pending[0] !== exp_pend) begin
        n_fail++;
        $display("FAIL same_cycle_pending c=%0d: got %b expected %b", c, pending[0], exp_pend);
      end
      tick();
    end
    raw_event = '0;
  endtask

  task automatic test_flush();
    logic exp_ev, exp_pend;
    coal_en = 2'b11; thresh = 8'd8; timeout = '0;
    for (int c = 0; c <= 25; c++) begin
      raw_event = '0;
      raw_event[0] = (c == 2 || c == 5 || c == 8);
      flush = (c == 20 || c == 22);
      exp_ev   = (c == 21);
      exp_pend = (c >= 3 && c <= 20);
      n_checks++;
      if (event_intr !== {1'b0, exp_ev}) begin
        n_fail++;
        $display("FAIL flush_pulse c=%0d: got %b expected %b", c, event_intr, {1'b0, exp_ev});
      end
      n_checks++;
      if (pending[0] !== exp_pend) begin
        n_fail++;
        $display("FAIL flush_pending c=%0d: got %b expected %b", c, pending[0], exp_pend);
      end
      tick();
    end
    raw_event = '0; flush = 1'b0;
  endtask

  task automatic test_cfg_change();
    logic exp_ev, exp_pend;
    timeout = '0;
    for (int c = 0; c <= 14; c++) begin
      raw_event = '0;
      raw_event[0] = (c == 0 || c == 1 || c == 2 || c == 8);
      thresh = (c >= 4 && c < 7) ? 8'd2 : 8'd8;
      coal_en = 2'b11;
      coal_en[0] = !(c == 11);
      exp_ev   = (c == 5 || c == 12);
      exp_pend = (c >= 1 && c <= 4) || (c >= 9 && c <= 11);
      n_checks++;
      if (event_intr[0] !== exp_ev) begin
        n_fail++;
        $display("FAIL cfg_change_pulse c=%0d: got %b expected %b", c, event_intr[0], exp_ev);
      end
      n_checks++;
      if (pending[0] !== exp_pend) begin
        n_fail++;
        $display("FAIL cfg_change_pending c=%0d: got %b expected %b", c, pending[0], exp_pend);
      end
      tick();
    end
    raw_event = '0; coal_en = 2'b11; thresh = 8'd8;
  endtask

  task automatic test_mid_reset();
    coal_en = 2'b11; thresh = 8'd8; timeout = 16'd4;
    for (int c = 0; c <= 1; c++) begin
      raw_event = '0;
      raw_event[0] = 1'b1;
      tick();
    end
    raw_event = '0;
    n_checks++;
    if (pending[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_precond: pending got %b expected 1", pending[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({event_intr, pending, sat} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got %b expected 000000", {event_intr, pending, sat});
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      n_checks++;
      if ({event_intr, pending} !== 4'b0) begin
        n_fail++;
        $display("FAIL mid_reset_after c=%0d: got %b expected 0000", c, {event_intr, pending});
      end
      tick();
    end
    timeout = '0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_ev, exp_pend;
    s_coal = 2'b11; s_thresh = 2'd0; s_timeout = '0;
    for (int c = 0; c <= 6; c++) begin
      s_raw = '0;
      s_raw[0] = (c == 1 || c == 3);
      s_raw[1] = (c == 5);
      exp_ev = {1'(c == 6), 1'(c == 2 || c == 4)};
      n_checks++;
      if (s_event !== exp_ev) begin
        n_fail++;
        $display("FAIL sat_thresh0_pulse c=%0d: got %b expected %b", c, s_event, exp_ev);
      end
      n_checks++;
      if (s_pending !== 2'b00) begin
        n_fail++;
        $display("FAIL sat_thresh0_pending c=%0d: got %b expected 00", c, s_pending);
      end
      tick();
    end
    s_thresh = 2'd3;
    for (int c = 0; c <= 11; c++) begin
      s_raw = '0;
      s_raw[1] = (c == 0 || c == 1 || c == 2);
      s_raw[0] = (c == 4);
      s_flush = (c == 9);
      exp_ev   = {1'(c == 3), 1'(c == 10)};
      exp_pend = {1'(c >= 1 && c <= 2), 1'(c >= 5 && c <= 9)};
      n_checks++;
      if (s_event !== exp_ev) begin
        n_fail++;
        $display("FAIL sat_mixed_pulse c=%0d: got %b expected %b", c, s_event, exp_ev);
      end
      n_checks++;
      if (s_pending !== exp_pend) begin
        n_fail++;
        $display("FAIL sat_mixed_pending c=%0d: got %b expected %b", c, s_pending, exp_pend);
      end
      n_checks++;
      if (s_sat !== 2'b00) begin
        n_fail++;
        $display("FAIL sat_mixed_sat c=%0d: got %b expected 00", c, s_sat);
      end
      tick();
    end
    s_raw = '0; s_flush = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_bypass();
    test_threshold();
    test_timeout();
    test_same_cycle_timeout();
    test_flush();
    test_cfg_change();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
